// File: rtl/cpu_bus_responder_pkg.sv
// cpu_bus_responder_pkg: shared bus map (I/O offsets, status bits, state codes) for RTL, software and benches.
package cpu_bus_responder_pkg;
    localparam logic [15:0] IO_DATA_OFS = 16'h0000;
    localparam logic [15:0] IO_STAT_OFS = 16'h0001;
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_DROP  = 2;
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic [7:0] status_byte(input logic drop, input logic empty, input logic full);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_DROP] = drop;
        s[STAT_EMPTY] = empty;
        s[STAT_FULL] = full;
        return s;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO; a push on full is still accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         accept
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop;
    assign valid  = count != '0;
    assign empty  = !valid;
    assign full   = count == CW'(DEPTH);
    assign pop    = valid && ready;
    assign accept = push && (!full || pop);
    assign dout   = valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(accept) - CW'(pop);
        end
    end
endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: boot loader fills RAM while holding the CPU in reset, then serves CPU RAM/I-O accesses.
module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter int          MEM_AW     = 12,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] IO_BASE    = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic        cpu_rst,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic        ld_done,
    input  logic        ld_restart,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    input  logic [7:0]  in_data
);
    localparam int RAM_BYTES = 1 << MEM_AW;
    logic [7:0]        ram [RAM_BYTES];
    logic [0:0]        state;
    logic [MEM_AW-1:0] ptr;
    logic              ld_ovf, drop, full, empty, accept;
    logic              run, is_ram, is_data, is_stat, push;
    logic [7:0]        rd_next;
    assign run      = state == ST_RUN;
    assign cpu_rst  = !run;
    assign ld_ready = !run;
    assign is_ram   = 32'(addr) < RAM_BYTES;
    assign is_data  = addr == IO_BASE + IO_DATA_OFS;
    assign is_stat  = addr == IO_BASE + IO_STAT_OFS;
    assign push     = run && we && is_data;
    always_comb begin
        rd_next = is_ram ? ram[addr[MEM_AW-1:0]] :
                  is_data ? in_data :
                  is_stat ? status_byte(drop, empty, full) : 8'h00;
    end
    // Loader owns the write port in LOAD, the CPU in RUN; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (!rst && !run && ld_valid) ram[ptr] <= ld_data;
        else if (!rst && run && we && is_ram) ram[addr[MEM_AW-1:0]] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_LOAD;
            ptr    <= '0;
            ld_ovf <= 1'b0;
            drop   <= 1'b0;
            rdata  <= 8'h00;
        end else begin
            if (!run) begin
                if (ld_valid) begin
                    ptr <= ptr + 1'b1;
                    if (&ptr) ld_ovf <= 1'b1;
                end
                if (ld_done) state <= ST_RUN;
            end else if (ld_restart) begin
                state  <= ST_LOAD;
                ptr    <= '0;
                ld_ovf <= 1'b0;
            end
            if (push && !accept) drop <= 1'b1;
            else if (run && we && is_stat) drop <= 1'b0;
            rdata <= rd_next;
        end
    end
    sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (wdata),
        .ready (out_ready),
        .valid (out_valid),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .accept(accept)
    );
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed scenarios plus random traffic checked every cycle against a queue/array model.
module tb_cpu_bus_responder;
    localparam int          AW    = 4;
    localparam int          RB    = 1 << AW;
    localparam int          DEPTH = 8;
    localparam logic [15:0] IOB   = 16'hFF00;
    localparam logic [15:0] IOS   = 16'hFF01;

    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] addr = 16'h0;
    logic [7:0]  wdata = 8'h0, ld_data = 8'h0, in_data = 8'h0;
    logic        we = 1'b0, ld_valid = 1'b0, ld_done = 1'b0, ld_restart = 1'b0, out_ready = 1'b0;
    logic [7:0]  rdata, out_data;
    logic        cpu_rst, ld_ready, out_valid;

    int n_chk = 0, n_pass = 0;

    cpu_bus_responder #(.MEM_AW(AW), .FIFO_DEPTH(DEPTH), .IO_BASE(IOB)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
        .cpu_rst(cpu_rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_done(ld_done), .ld_restart(ld_restart), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .in_data(in_data)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Behavioural model
    bit         m_run, m_ovf, m_drop, started, m_rd_known;
    int         m_ptr;
    logic [7:0] m_ram [RB];
    bit         m_known [RB];
    logic [7:0] m_q [$];
    logic [7:0] m_rd;

    always @(posedge clk) begin : model
        logic [7:0] nxt;
        bit nk, pop, push, acc;
        if (rst) begin
            m_run = 0; m_ptr = 0; m_ovf = 0; m_drop = 0;
            m_q.delete();
            m_rd = 8'h00; m_rd_known = 1;
        end else begin
            nk = 1;
            if (int'(addr) < RB) begin
                nxt = m_ram[int'(addr)]; nk = m_known[int'(addr)];
            end else if (addr == IOB) nxt = in_data;
            else if (addr == IOS) nxt = {5'b0, m_drop, m_q.size() == 0, m_q.size() == DEPTH};
            else nxt = 8'h00;
            pop  = m_q.size() != 0 && out_ready;
            push = m_run && we && addr == IOB;
            acc  = push && (m_q.size() < DEPTH || pop);
            if (push && !acc) m_drop = 1;
            else if (m_run && we && addr == IOS) m_drop = 0;
            if (!m_run) begin
                if (ld_valid) begin
                    m_ram[m_ptr] = ld_data; m_known[m_ptr] = 1;
                    if (m_ptr == RB - 1) m_ovf = 1;
                    m_ptr = (m_ptr + 1) % RB;
                end
                if (ld_done) m_run = 1;
            end else begin
                if (we && int'(addr) < RB) begin
                    m_ram[int'(addr)] = wdata; m_known[int'(addr)] = 1;
                end
                if (ld_restart) begin
                    m_run = 0; m_ptr = 0; m_ovf = 0;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(wdata);
            m_rd = nxt; m_rd_known = nk;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("cpu_rst", cpu_rst, !m_run);
            check("ld_ready", ld_ready, !m_run);
            check("out_valid", out_valid, m_q.size() != 0);
            check("out_data", out_data, m_q.size() != 0 ? m_q[0] : 8'h00);
            if (m_rd_known) check("rdata", rdata, m_rd);
            check("ptr", dut.ptr, m_ptr);
            check("ld_ovf", dut.ld_ovf, m_ovf);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        step(); step();
        check("rst_cpu_rst", cpu_rst, 1'b1);
        check("rst_ld_ready", ld_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_rdata", rdata, 8'h00);
        rst = 0;
        // Load two bytes and hand over
        ld_valid = 1; ld_data = 8'h01; step();
        ld_data = 8'h02; step();
        ld_valid = 0; ld_done = 1; step();
        check("handover_cpu_rst", cpu_rst, 1'b0);
        ld_done = 0; addr = 16'h0; step();
        check("read0", rdata, 8'h01);
        addr = 16'h1; step();
        check("read1", rdata, 8'h02);
        // FIFO full and drop
        out_ready = 0; we = 1; addr = IOB;
        for (int i = 0; i < 9; i++) begin
            wdata = 8'hA0 + 8'(i); step();
        end
        we = 0; addr = IOS; step();
        check("status_full_drop", rdata, 8'h05);
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check("drain_order", out_data, 8'hA0 + 8'(i)); step();
        end
        step();
        check("status_empty_drop", rdata, 8'h06);
        out_ready = 0;
        // Push on full with simultaneous pop
        we = 1; addr = IOS; step();
        addr = IOB;
        for (int i = 0; i < 8; i++) begin
            wdata = 8'h90 + 8'(i); step();
        end
        wdata = 8'hB0; out_ready = 1; step();
        we = 0; out_ready = 0; addr = IOS; step();
        check("status_full_nodrop", rdata, 8'h01);
        check("head_after_pushpop", out_data, 8'h91);
        out_ready = 1;
        for (int i = 0; i < 8; i++) step();
        out_ready = 0;
        // Restart mid-run
        we = 1; addr = 16'h3; wdata = 8'h33; step();
        we = 0; ld_restart = 1; step();
        check("restart_cpu_rst", cpu_rst, 1'b1);
        check("restart_ptr", dut.ptr, 0);
        ld_restart = 0; we = 1; wdata = 8'h55; step();
        we = 0; step();
        check("load_write_ignored", rdata, 8'h33);
        // Load wrap
        ld_valid = 1;
        for (int i = 1; i <= 17; i++) begin
            ld_data = 8'(i); step();
        end
        ld_valid = 0;
        check("wrap_ovf", dut.ld_ovf, 1'b1);
        check("wrap_ptr", dut.ptr, 1);
        addr = 16'h0; step();
        check("wrap_ram0", rdata, 8'h11);
        // FIFO survives restart, then reset mid-load
        ld_done = 1; step();
        ld_done = 0; we = 1; addr = IOB; wdata = 8'h77; step();
        wdata = 8'h78; step();
        we = 0; ld_restart = 1; step();
        ld_restart = 0;
        check("fifo_kept_valid", out_valid, 1'b1);
        check("fifo_kept_data", out_data, 8'h77);
        ld_valid = 1;
        for (int i = 0; i < 5; i++) begin
            ld_data = 8'hC0 + 8'(i); step();
        end
        ld_valid = 0; rst = 1; step();
        rst = 0;
        check("midload_rst_cpu_rst", cpu_rst, 1'b1);
        check("midload_rst_ptr", dut.ptr, 0);
        check("midload_rst_out_valid", out_valid, 1'b0);
        check("midload_rst_rdata", rdata, 8'h00);
        for (int i = 0; i < 5; i++) begin
            addr = 16'(i); step();
            check("ram_preserved", rdata, 8'hC0 + 8'(i));
        end
        addr = IOB; in_data = 8'h5A; step();
        check("io_in_data", rdata, 8'h5A);
        addr = 16'hFF02; step();
        check("unmapped_io", rdata, 8'h00);
        addr = 16'(RB); step();
        check("unmapped_ram_edge", rdata, 8'h00);
        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst        = $urandom_range(0, 399) == 0;
            ld_valid   = $urandom_range(0, 1) == 1;
            ld_data    = 8'($urandom);
            ld_done    = $urandom_range(0, 19) == 0;
            ld_restart = $urandom_range(0, 39) == 0;
            we         = $urandom_range(0, 1) == 1;
            wdata      = 8'($urandom);
            in_data    = 8'($urandom);
            case ($urandom_range(0, 4))
                0, 1:    addr = 16'($urandom_range(0, RB + 3));
                2:       addr = IOB;
                3:       addr = IOS;
                default: addr = 16'($urandom);
            endcase
            out_ready  = ((i / 150) % 2 == 0) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
            step();
        end
        rst = 0; we = 0; ld_valid = 0; ld_done = 0; ld_restart = 0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 Parameters SHALL be as follows.
- MEM_AW, default 12: RAM address width; RAM holds 2^MEM_AW bytes.
- FIFO_DEPTH, default 8: output FIFO entries; power of two.
- IO_BASE, default 16'hFF00: base address of the I/O registers.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- addr  in  16  CPU bus address.
- wdata  in  8  CPU write data.
- we  in  1  CPU write strobe.
- rdata  out  8  CPU read data.
- cpu_rst  out  1  hold-reset to the CPU.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_ready  out  1  loader may present a byte.
- ld_done  in  1  pulse: image complete.
- ld_restart  in  1  pulse: return to load mode.
- out_valid  out  1  FIFO head valid.
- out_data  out  8  FIFO head byte.
- out_ready  in  1  consumer accepts the head byte.
- in_data  in  8  external input byte.

Function
REQ-003 The block SHALL have two states, LOAD and RUN; LOAD drives cpu_rst=1 and ld_ready=1, RUN drives cpu_rst=0 and ld_ready=0.
REQ-004 In LOAD, each cycle with ld_valid=1 SHALL write ld_data to RAM[ptr] and then increment ptr modulo 2^MEM_AW.
REQ-005 An increment of ptr from 2^MEM_AW-1 to 0 SHALL set the sticky flag ld_ovf.
REQ-006 In LOAD, ld_done=1 SHALL move the state to RUN on the next cycle; a byte with ld_valid=1 in the same cycle is still written.
REQ-007 In RUN, ld_restart=1 SHALL move the state to LOAD, clear ptr and clear ld_ovf; ld_done SHALL be ignored in RUN and ld_restart SHALL be ignored in LOAD.
REQ-008 Read latency SHALL be one cycle: rdata is registered from the addr value presented in the previous cycle, for RAM and I/O alike.
REQ-009 Read decode SHALL be as follows.
- addr < 2^MEM_AW: RAM byte.
- addr == IO_BASE: in_data, sampled at the same edge as rdata is registered.
- addr == IO_BASE+1: status {5'b0, drop, empty, full}.
- Any other address: 8'h00.
REQ-010 In RUN, we=1 with addr < 2^MEM_AW SHALL write wdata to RAM at the same edge.
REQ-011 In RUN, we=1 with addr == IO_BASE SHALL push wdata to the FIFO.
REQ-012 In RUN, we=1 with addr == IO_BASE+1 SHALL clear the drop flag; we=1 to any other address SHALL be ignored.
REQ-013 CPU writes in LOAD SHALL be ignored.
REQ-014 A CPU read and a CPU write to the same RAM address in one cycle SHALL return the old data.
REQ-015 A push SHALL be accepted when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
REQ-016 A push that is not accepted SHALL be dropped and SHALL set the sticky flag drop.
REQ-017 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-018 out_valid SHALL equal (count != 0), out_data SHALL be the head entry, and ordering SHALL be FIFO.
REQ-019 Status bits full and empty SHALL be count == FIFO_DEPTH and count == 0; count SHALL be $clog2(FIFO_DEPTH)+1 bits wide, and read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 A push and a pop in the same cycle when count is nonzero and below FIFO_DEPTH SHALL leave count unchanged.
REQ-021 The FIFO and the drop flag SHALL keep their contents across LOAD/RUN transitions.

Reset
REQ-022 On rst the block SHALL set:
- state = LOAD, so cpu_rst = 1 and ld_ready = 1;
- ptr = 0 and ld_ovf = 0;
- FIFO empty, so out_valid = 0 and out_data = 8'h00;
- drop = 0 and rdata = 8'h00.
REQ-023 RAM contents SHALL NOT be cleared by rst.
REQ-024 rst asserted in RUN or mid-load SHALL return the block to LOAD with ptr = 0 on the next cycle.

Structure
REQ-025 IO_BASE offsets, status bit positions and state encodings SHALL live in the shared bus-map package, which is also used by software and benches.
REQ-026 The FIFO SHALL be a separate sub-module, sync_fifo, parameterized by width and depth.
REQ-027 RAM SHALL be inferred as a single-port synchronous array inside cpu_bus_responder.

Verification
REQ-028 Loader and handover: load bytes 8'h01, 8'h02 at addresses 0 and 1, then pulse ld_done -> cpu_rst falls one cycle later; addr=0 gives rdata=8'h01 next cycle, addr=1 gives rdata=8'h02.
REQ-029 Load wrap: with MEM_AW=4, load 17 bytes -> RAM[0] holds byte 17 and ld_ovf=1.
REQ-030 FIFO full and drop: with out_ready=0, write 9 bytes 8'hA0..8'hA8 to IO_BASE -> status reads 8'h05 (full, drop); draining yields A0..A7 in order, then status reads 8'h06.
REQ-031 Push on full with pop: FIFO full, push 8'hB0 while out_ready=1 in the same cycle -> accepted, count stays 8, drop=0.
REQ-032 Restart mid-run: pulse ld_restart in RUN -> cpu_rst=1 next cycle, ptr=0; a CPU write of 8'h55 to address 3 is ignored and RAM[3] is unchanged.
REQ-033 Reset mid-load: assert rst after 5 loaded bytes -> state is LOAD, ptr=0, out_valid=0, and RAM[0..4] are preserved.
